// File: rtl/pic_int_control_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pic_int_control_pkg
// Description : Shared constants, FSM state type and the lowest-set-bit helper
//               for the 8259-compatible interrupt controller core.
// Revision    : 1.0 - initial release
// ============================================================================
package pic_int_control_pkg;

  // Command-word bit positions
  localparam int LTIM_BIT = 3;  // ICW1: 1 = level triggered, 0 = edge
  localparam int AEOI_BIT = 1;  // ICW4: automatic end of interrupt

  // OCW2 R/SL/EOI codes that are honoured
  localparam logic [2:0] EOI_NONSPEC = 3'b001;
  localparam logic [2:0] EOI_SPEC    = 3'b011;

  // INTA sequencer states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACK1  = 2'd1,
    ST_WAIT2 = 2'd2,
    ST_ACK2  = 2'd3
  } state_t;

  // Index of the lowest set bit (IR0 = highest priority). Returns 0 for an
  // all-zero vector; callers qualify with a reduction-OR.
  function automatic logic [2:0] f_lowest_idx(input logic [7:0] v);
    f_lowest_idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) f_lowest_idx = 3'(i);
    end
  endfunction

endpackage
`default_nettype wire

// File: rtl/pic_int_control_if.sv
`default_nettype none
// ============================================================================
// Module      : pic_int_control_if
// Description : Bundles the command words, request/acknowledge lines and the
//               read-back / vector outputs of the interrupt control block.
//               master = register block / CPU side, slave = pic_int_control.
// Revision    : 1.0 - initial release
// ============================================================================
interface pic_int_control_if;
  logic       init_done;  // ICW sequence complete
  logic [7:0] icw1;       // bit3 LTIM
  logic [7:0] icw2;       // bits[7:3] vector base
  logic [7:0] icw4;       // bit1 AEOI
  logic [7:0] ocw1;       // IMR, 1 = masked
  logic [7:0] ocw2;       // EOI command
  logic       ocw2_wr;    // one-cycle OCW2 write strobe
  logic [7:0] ir;         // request lines (synchronous)
  logic       inta_n;     // acknowledge, active low (synchronous)
  logic       int_out;    // interrupt to CPU
  logic [7:0] data_out;   // vector byte
  logic       data_oe;    // vector valid / drive bus
  logic [7:0] irr;        // request register read-back
  logic [7:0] isr;        // in-service register read-back

  modport master (
    output init_done, icw1, icw2, icw4, ocw1, ocw2, ocw2_wr, ir, inta_n,
    input  int_out, data_out, data_oe, irr, isr
  );

  modport slave (
    input  init_done, icw1, icw2, icw4, ocw1, ocw2, ocw2_wr, ir, inta_n,
    output int_out, data_out, data_oe, irr, isr
  );
endinterface
`default_nettype wire

// File: rtl/pic_int_control_priority_resolver.sv
`default_nettype none
// ============================================================================
// Module      : pic_int_control_priority_resolver
// Description : Fixed-priority resolver. Picks the lowest unmasked pending
//               request and reports whether it may interrupt the level that
//               is currently in service.
// Ports       : i_irr   - pending requests
//               i_imr   - mask, 1 = masked
//               i_isr   - in-service levels
//               o_cand  - candidate level
//               o_valid - candidate exists and outranks every in-service level
// Revision    : 1.0 - initial release
// ============================================================================
module pic_int_control_priority_resolver
  import pic_int_control_pkg::*;
(
  input  wire  logic [7:0] i_irr,
  input  wire  logic [7:0] i_imr,
  input  wire  logic [7:0] i_isr,
  output logic [2:0]       o_cand,
  output logic             o_valid
);

  logic [7:0] w_req;
  logic [2:0] w_isr_top;

  assign w_req     = i_irr & ~i_imr;
  assign o_cand    = f_lowest_idx(w_req);
  assign w_isr_top = f_lowest_idx(i_isr);
  assign o_valid   = (|w_req) && ((i_isr == 8'h00) || (o_cand < w_isr_top));

endmodule
`default_nettype wire

// File: rtl/pic_int_control.sv
`default_nettype none
// ============================================================================
// Module      : pic_int_control
// Description : IRR/ISR keeping, priority resolution, INT generation and the
//               two-pulse 8086 INTA sequencer that returns the vector byte.
// Ports       : clk   - system clock, rising edge
//               reset - synchronous, active-high
//               bus   - pic_int_control_if.slave (command words, IR, INTA,
//                       INT, vector byte/enable, IRR/ISR read-back)
// Revision    : 1.0 - initial release
// ============================================================================
module pic_int_control
  import pic_int_control_pkg::*;
#(
  parameter int unsigned SPURIOUS_IR = 7
) (
  input wire logic          clk,
  input wire logic          reset,
  pic_int_control_if.slave  bus
);

  localparam logic [2:0] c_SPUR_IR = 3'(SPURIOUS_IR);

  state_t     r_state, w_state_next;
  logic [7:0] r_irr, r_isr, r_ir_prev;
  logic       r_inta_prev, r_int, r_spur;
  logic [2:0] r_sel;

  logic       w_clr, w_ltim, w_aeoi, w_inta_fall, w_inta_rise;
  logic [2:0] w_cand;
  logic       w_valid;
  logic [7:0] w_ack_mask, w_eoi_mask, w_aeoi_mask, w_irr_next, w_isr_next;
  logic       w_data_oe;
  logic [7:0] w_data_out;
  logic       w_unused_bits;

  // Dropping init_done behaves exactly like reset.
  assign w_clr       = reset | ~bus.init_done;
  assign w_ltim      = bus.icw1[LTIM_BIT];
  assign w_aeoi      = bus.icw4[AEOI_BIT];
  assign w_inta_fall = r_inta_prev & ~bus.inta_n;
  assign w_inta_rise = ~r_inta_prev & bus.inta_n;

  pic_int_control_priority_resolver u_prio (
    .i_irr   (r_irr),
    .i_imr   (bus.ocw1),
    .i_isr   (r_isr),
    .o_cand  (w_cand),
    .o_valid (w_valid)
  );

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_inta_fall) w_state_next = ST_ACK1;
      ST_ACK1:  w_state_next = ST_WAIT2;
      ST_WAIT2: if (w_inta_fall) w_state_next = ST_ACK2;
      ST_ACK2:  if (w_inta_rise) w_state_next = ST_IDLE;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  // Register updates. EOI and AEOI clears act on the old ISR; the ACK1 set
  // is OR-ed in last so a simultaneous set of the same bit survives.
  always_comb begin
    w_ack_mask  = ((r_state == ST_ACK1) && !r_spur) ? (8'd1 << r_sel) : 8'h00;
    w_aeoi_mask = ((r_state == ST_ACK2) && w_inta_rise && w_aeoi && !r_spur)
                  ? (8'd1 << r_sel) : 8'h00;
    w_eoi_mask  = 8'h00;
    if (bus.ocw2_wr) begin
      case (bus.ocw2[7:5])
        EOI_NONSPEC: if (|r_isr) w_eoi_mask = 8'd1 << f_lowest_idx(r_isr);
        EOI_SPEC:    w_eoi_mask = 8'd1 << bus.ocw2[2:0];
        default:     w_eoi_mask = 8'h00;
      endcase
    end
    w_isr_next = (r_isr & ~(w_eoi_mask | w_aeoi_mask)) | w_ack_mask;
    w_irr_next = (w_ltim ? bus.ir : (r_irr | (bus.ir & ~r_ir_prev))) & ~w_ack_mask;
  end

  // State register and datapath registers
  always_ff @(posedge clk) begin
    if (w_clr) begin
      r_state     <= ST_IDLE;
      r_irr       <= 8'h00;
      r_isr       <= 8'h00;
      r_ir_prev   <= 8'h00;
      r_inta_prev <= 1'b1;
      r_int       <= 1'b0;
      r_sel       <= 3'd0;
      r_spur      <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_irr       <= w_irr_next;
      r_isr       <= w_isr_next;
      r_ir_prev   <= bus.ir;
      r_inta_prev <= bus.inta_n;
      // INT is held low from the first acknowledge until back in IDLE.
      r_int       <= (r_state == ST_IDLE && w_state_next == ST_IDLE) ? w_valid : 1'b0;
      if (r_state == ST_IDLE && w_inta_fall) begin
        r_sel  <= w_valid ? w_cand : c_SPUR_IR;
        r_spur <= ~w_valid;
      end
    end
  end

  // Outputs: vector only during the second pulse while INTA is low
  always_comb begin
    w_data_oe  = (r_state == ST_ACK2) && !bus.inta_n;
    w_data_out = w_data_oe ? {bus.icw2[7:3], r_sel} : 8'h00;
  end

  assign bus.int_out  = r_int;
  assign bus.data_oe  = w_data_oe;
  assign bus.data_out = w_data_out;
  assign bus.irr      = r_irr;
  assign bus.isr      = r_isr;

  // Command-word bits this block does not interpret
  assign w_unused_bits = ^{bus.icw1[7:4], bus.icw1[2:0], bus.icw2[2:0],
                           bus.icw4[7:2], bus.icw4[0], bus.ocw2[4:3]};

endmodule
`default_nettype wire

// File: tb/tb_pic_int_control.sv
`default_nettype none
// ============================================================================
// Module      : tb_pic_int_control
// Description : Self-checking bench for pic_int_control. Expected vectors go
//               into a queue; a monitor pops one on every vector presented.
//               Register/INT values are compared directly after clock edges.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pic_int_control;

  logic clk = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;
  logic [7:0] exp_q[$];
  logic       prev_oe = 1'b0;

  pic_int_control_if bus ();

  pic_int_control #(.SPURIOUS_IR(7)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Vector monitor
  always @(negedge clk) begin
    if (bus.data_oe && bus.inta_n) begin
      checks++; failures++;
      $display("FAIL oe_while_inta_high data_oe=%0b inta_n=%0b", bus.data_oe, bus.inta_n);
    end
    if (bus.data_oe && !prev_oe) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_vector got=%02h expected=none", bus.data_out);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (bus.data_out !== e) begin
          failures++;
          $display("FAIL vector got=%02h expected=%02h", bus.data_out, e);
        end
      end
    end
    prev_oe <= bus.data_oe;
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%02h expected=%02h", name, act, exp);
    end
  endtask

  task automatic pulse();
    bus.inta_n = 1'b0; cyc(3);
    bus.inta_n = 1'b1; cyc(3);
  endtask

  task automatic ack(input logic [7:0] vec);
    exp_q.push_back(vec);
    pulse();
    pulse();
  endtask

  task automatic eoi(input logic [7:0] cmd);
    bus.ocw2 = cmd; bus.ocw2_wr = 1'b1; cyc(1);
    bus.ocw2_wr = 1'b0; cyc(1);
  endtask

  task automatic raise(input logic [7:0] lines);
    bus.ir = lines; cyc(1);
    bus.ir = 8'h00; cyc(1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    bus.init_done = 1'b0; bus.icw1 = 8'h13; bus.icw2 = 8'h40; bus.icw4 = 8'h01;
    bus.ocw1 = 8'h00; bus.ocw2 = 8'h00; bus.ocw2_wr = 1'b0;
    bus.ir = 8'h00; bus.inta_n = 1'b1;
    cyc(3);
    reset = 1'b0; cyc(1);
    chk("reset_irr", bus.irr, 8'h00);
    chk("reset_isr", bus.isr, 8'h00);
    chk("reset_int", {7'd0, bus.int_out}, 8'h00);
    chk("reset_oe",  {7'd0, bus.data_oe}, 8'h00);
    bus.init_done = 1'b1; cyc(1);

    // Single request IR3
    bus.ir = 8'h08; cyc(1);
    chk("t1_irr", bus.irr, 8'h08);
    chk("t1_int_lag", {7'd0, bus.int_out}, 8'h00);
    bus.ir = 8'h00; cyc(1);
    chk("t1_int", {7'd0, bus.int_out}, 8'h01);
    ack(8'h43);
    chk("t1_isr", bus.isr, 8'h08);
    chk("t1_irr_ack", bus.irr, 8'h00);
    chk("t1_int_off", {7'd0, bus.int_out}, 8'h00);
    eoi(8'h20);
    chk("t1_eoi", bus.isr, 8'h00);

    // IR5 and IR2 together
    raise(8'h24);
    chk("t2_int", {7'd0, bus.int_out}, 8'h01);
    ack(8'h42);
    chk("t2_isr", bus.isr, 8'h04);
    chk("t2_irr", bus.irr, 8'h20);
    chk("t2_int_blocked", {7'd0, bus.int_out}, 8'h00);
    eoi(8'h20); cyc(1);
    chk("t2_int_ir5", {7'd0, bus.int_out}, 8'h01);
    ack(8'h45);
    chk("t2_isr5", bus.isr, 8'h20);
    eoi(8'h20);

    // Masking
    bus.ocw1 = 8'h04;
    raise(8'h04); cyc(1);
    chk("t3_irr", bus.irr, 8'h04);
    chk("t3_int_masked", {7'd0, bus.int_out}, 8'h00);
    bus.ocw1 = 8'h00; cyc(2);
    chk("t3_int_unmasked", {7'd0, bus.int_out}, 8'h01);
    ack(8'h42);
    eoi(8'h20);

    // Nesting and specific EOI
    raise(8'h08); ack(8'h43);
    chk("t4_isr", bus.isr, 8'h08);
    raise(8'h40); cyc(1);
    chk("t4_int_lower", {7'd0, bus.int_out}, 8'h00);
    raise(8'h02); cyc(1);
    chk("t4_int_higher", {7'd0, bus.int_out}, 8'h01);
    ack(8'h41);
    chk("t4_isr_nest", bus.isr, 8'h0A);
    eoi(8'h61);
    chk("t4_spec_eoi", bus.isr, 8'h08);
    eoi(8'h20);
    ack(8'h46);
    eoi(8'h20);
    chk("t4_drained", bus.isr | bus.irr, 8'h00);

    // Automatic EOI
    bus.icw4 = 8'h03;
    raise(8'h10);
    exp_q.push_back(8'h44);
    pulse();
    chk("t5_isr_set", bus.isr, 8'h10);
    pulse();
    chk("t5_isr_aeoi", bus.isr, 8'h00);
    bus.icw4 = 8'h01;

    // Spurious acknowledge
    exp_q.push_back(8'h47);
    pulse();
    chk("t6_isr_p1", bus.isr, 8'h00);
    pulse();
    chk("t6_isr_p2", bus.isr, 8'h00);

    // Reset during WAIT2, then a clean cycle proves the FSM is back in IDLE
    raise(8'h02);
    pulse();
    chk("t7_isr_pre", bus.isr, 8'h02);
    reset = 1'b1; cyc(1);
    reset = 1'b0;
    chk("t7_irr", bus.irr, 8'h00);
    chk("t7_isr", bus.isr, 8'h00);
    chk("t7_int", {7'd0, bus.int_out}, 8'h00);
    chk("t7_oe",  {7'd0, bus.data_oe}, 8'h00);
    raise(8'h04);
    ack(8'h42);
    chk("t7_isr_after", bus.isr, 8'h04);

    cyc(3);
    chk("queue_empty", 8'(exp_q.size()), 8'h00);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
